// File: rtl/csr_timer.sv
// Constant timer for the LA32 CSR file: TID/TCFG/TVAL/TICLR plus the 64-bit
// stable counter read by rdcntvl/rdcntvh/rdcntid.
module csr_timer #(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic [31:0] csr_rvalue,
  output logic        timer_int,
  output logic [63:0] stable_cnt,
  output logic [31:0] tid
);

  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;

  typedef struct packed {
    logic [29:0] init_val;
    logic        periodic;
    logic        en;
  } tcfg_t;

  logic [31:0] tid_q, tid_d;
  tcfg_t       tcfg_q, tcfg_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tmr_en_q, tmr_en_d;
  logic        timer_int_q, timer_int_d;
  logic [63:0] stable_cnt_q, stable_cnt_d;

  logic        tid_wr, tcfg_wr, ticlr_wr;
  tcfg_t       tcfg_merged;
  logic        expire;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] mask,
                                        input logic [31:0] wdata);
    return (mask & wdata) | (~mask & old_val);
  endfunction

  function automatic logic [31:0] load_val(input tcfg_t cfg);
    return {cfg.init_val, 2'b00};
  endfunction

  assign tid_wr      = csr_we && (csr_num == CSR_TID);
  assign tcfg_wr     = csr_we && (csr_num == CSR_TCFG);
  assign ticlr_wr    = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];
  assign tcfg_merged = tcfg_t'(merge(tcfg_q, csr_wmask, csr_wvalue));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    tid_d        = tid_q;
    tcfg_d       = tcfg_q;
    cnt_d        = cnt_q;
    tmr_en_d     = tmr_en_q;
    timer_int_d  = timer_int_q;
    stable_cnt_d = stable_cnt_q + 64'd1;
    expire       = 1'b0;

    if (tid_wr) tid_d = merge(tid_q, csr_wmask, csr_wvalue);

    // A TCFG write outranks counting; En=0 freezes cnt where it is.
    if (tcfg_wr) begin
      tcfg_d   = tcfg_merged;
      tmr_en_d = tcfg_merged.en;
      if (tcfg_merged.en) cnt_d = load_val(tcfg_merged);
    end else if (tmr_en_q && (cnt_q != 32'd0)) begin
      cnt_d = cnt_q - 32'd1;
    end else if (tmr_en_q) begin
      expire = 1'b1;
      if (tcfg_q.periodic) begin
        cnt_d = load_val(tcfg_q);
      end else begin
        cnt_d    = 32'hFFFF_FFFF;
        tmr_en_d = 1'b0;
      end
    end

    // Expiry is applied after the clear so it wins a same-cycle race.
    if (ticlr_wr) timer_int_d = 1'b0;
    if (expire)   timer_int_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tid_q        <= TID_RESET;
      tcfg_q       <= '0;
      cnt_q        <= 32'hFFFF_FFFF;
      tmr_en_q     <= 1'b0;
      timer_int_q  <= 1'b0;
      stable_cnt_q <= 64'd0;
    end else begin
      tid_q        <= tid_d;
      tcfg_q       <= tcfg_d;
      cnt_q        <= cnt_d;
      tmr_en_q     <= tmr_en_d;
      timer_int_q  <= timer_int_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  always_comb begin
    csr_rvalue = 32'd0;
    case (csr_num)
      CSR_TID:  csr_rvalue = tid_q;
      CSR_TCFG: csr_rvalue = tcfg_q;
      CSR_TVAL: csr_rvalue = cnt_q;
      default:  csr_rvalue = 32'd0;
    endcase
  end

  assign timer_int  = timer_int_q;
  assign stable_cnt = stable_cnt_q;
  assign tid        = tid_q;

endmodule

// File: tb/tb_csr_timer.sv
// Directed bench for csr_timer: reset, one-shot, periodic, TICLR races,
// freeze/reload, zero load, TID masking and mid-count reset.
module tb_csr_timer;

  localparam logic [13:0] TID   = 14'h40;
  localparam logic [13:0] TCFG  = 14'h41;
  localparam logic [13:0] TVAL  = 14'h42;
  localparam logic [13:0] TICLR = 14'h44;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [13:0] csr_num = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wmask = '0;
  logic [31:0] csr_wvalue = '0;
  logic [31:0] csr_rvalue;
  logic        timer_int;
  logic [63:0] stable_cnt;
  logic [31:0] tid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] v;

  csr_timer dut (
    .clk        (clk),
    .resetn     (resetn),
    .csr_num    (csr_num),
    .csr_we     (csr_we),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .csr_rvalue (csr_rvalue),
    .timer_int  (timer_int),
    .stable_cnt (stable_cnt),
    .tid        (tid)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [13:0] num, input logic [31:0] mask,
                           input logic [31:0] val);
    csr_num = num; csr_we = 1'b1; csr_wmask = mask; csr_wvalue = val;
    @(posedge clk);
    #1;
    csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] val);
    csr_num = num;
    #1;
    val = csr_rvalue;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(10);
    n_checks++; if (stable_cnt !== 64'd10) begin n_fail++; $display("FAIL reset_stable_cnt got=%0d exp=10", stable_cnt); end
    rd(TVAL, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_tval got=%h exp=ffffffff", v); end
    n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL reset_int got=%b exp=0", timer_int); end
    rd(TID, v);
    n_checks++; if (v !== 32'h0 || tid !== 32'h0) begin n_fail++; $display("FAIL reset_tid got=%h/%h exp=0", v, tid); end
    rd(TCFG, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_tcfg got=%h exp=0", v); end
  endtask

  task automatic test_oneshot;
    csr_write(TCFG, 32'hFFFF_FFFF, 32'h5);
    for (int i = 4; i >= 0; i--) begin
      rd(TVAL, v);
      n_checks++; if (v !== 32'(i) || timer_int !== 1'b0) begin n_fail++; $display("FAIL oneshot_count got=%h int=%b exp=%h int=0", v, timer_int, 32'(i)); end
      tick();
    end
    rd(TVAL, v);
    n_checks++; if (timer_int !== 1'b1 || v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL oneshot_expire got int=%b tval=%h exp int=1 tval=ffffffff", timer_int, v); end
    tick(6);
    rd(TVAL, v);
    n_checks++; if (timer_int !== 1'b1 || v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL oneshot_hold got int=%b tval=%h exp int=1 tval=ffffffff", timer_int, v); end
    csr_write(TICLR, 32'h1, 32'h1);
    n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear got=%b exp=0", timer_int); end
    tick(8);
    n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL oneshot_no_reexpire got=%b exp=0", timer_int); end
    rd(TCFG, v);
    n_checks++; if (v !== 32'h5) begin n_fail++; $display("FAIL oneshot_tcfg_read got=%h exp=5", v); end
  endtask

  task automatic test_periodic;
    csr_write(TCFG, 32'hFFFF_FFFF, 32'h7);
    rd(TVAL, v);
    n_checks++; if (v !== 32'd4) begin n_fail++; $display("FAIL periodic_load got=%h exp=4", v); end
    tick(4);
    rd(TVAL, v);
    n_checks++; if (v !== 32'd0 || timer_int !== 1'b0) begin n_fail++; $display("FAIL periodic_zero got=%h int=%b exp=0 int=0", v, timer_int); end
    tick();
    rd(TVAL, v);
    n_checks++; if (v !== 32'd4 || timer_int !== 1'b1) begin n_fail++; $display("FAIL periodic_exp1 got=%h int=%b exp=4 int=1", v, timer_int); end
    csr_write(TICLR, 32'h1, 32'h1);
    rd(TVAL, v);
    n_checks++; if (v !== 32'd3 || timer_int !== 1'b0) begin n_fail++; $display("FAIL periodic_clear got=%h int=%b exp=3 int=0", v, timer_int); end
    tick(3);
    n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL periodic_low got=%b exp=0", timer_int); end
    tick();
    rd(TVAL, v);
    n_checks++; if (v !== 32'd4 || timer_int !== 1'b1) begin n_fail++; $display("FAIL periodic_exp2 got=%h int=%b exp=4 int=1", v, timer_int); end
  endtask

  task automatic test_ticlr_race;
    tick(4);
    rd(TVAL, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL race_setup got=%h exp=0", v); end
    csr_write(TICLR, 32'h1, 32'h1);
    rd(TVAL, v);
    n_checks++; if (timer_int !== 1'b1 || v !== 32'd4) begin n_fail++; $display("FAIL race_expiry_wins got int=%b tval=%h exp int=1 tval=4", timer_int, v); end
    csr_write(TICLR, 32'h0, 32'h1);
    n_checks++; if (timer_int !== 1'b1) begin n_fail++; $display("FAIL race_mask0 got=%b exp=1", timer_int); end
    csr_write(TICLR, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
    rd(TICLR, v);
    n_checks++; if (timer_int !== 1'b1 || v !== 32'h0) begin n_fail++; $display("FAIL race_other_bits got int=%b rd=%h exp int=1 rd=0", timer_int, v); end
  endtask

  task automatic test_freeze_reload;
    rd(TVAL, v);
    n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL freeze_setup got=%h exp=2", v); end
    csr_write(TCFG, 32'h3, 32'h0);
    rd(TCFG, v);
    n_checks++; if (v !== 32'h4) begin n_fail++; $display("FAIL freeze_tcfg got=%h exp=4", v); end
    tick(3);
    rd(TVAL, v);
    n_checks++; if (v !== 32'd2 || timer_int !== 1'b1) begin n_fail++; $display("FAIL freeze_hold got=%h int=%b exp=2 int=1", v, timer_int); end
    csr_write(TCFG, 32'hFFFF_FFFF, 32'h9);
    rd(TVAL, v);
    n_checks++; if (v !== 32'd8) begin n_fail++; $display("FAIL reload got=%h exp=8", v); end
    csr_write(TVAL, 32'hFFFF_FFFF, 32'h55);
    rd(TVAL, v);
    n_checks++; if (v !== 32'd7) begin n_fail++; $display("FAIL tval_readonly got=%h exp=7", v); end
    csr_write(TICLR, 32'h1, 32'h1);
    n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL freeze_clear got=%b exp=0", timer_int); end
  endtask

  task automatic test_zero_load;
    csr_write(TCFG, 32'hFFFF_FFFF, 32'h3);
    rd(TVAL, v);
    n_checks++; if (v !== 32'd0 || timer_int !== 1'b0) begin n_fail++; $display("FAIL zero_load got=%h int=%b exp=0 int=0", v, timer_int); end
    tick();
    n_checks++; if (timer_int !== 1'b1) begin n_fail++; $display("FAIL zero_first got=%b exp=1", timer_int); end
    csr_write(TICLR, 32'h1, 32'h1);
    n_checks++; if (timer_int !== 1'b1) begin n_fail++; $display("FAIL zero_every_cycle got=%b exp=1", timer_int); end
  endtask

  task automatic test_tid;
    csr_write(TID, 32'hFFFF_0000, 32'hABCD_1234);
    rd(TID, v);
    n_checks++; if (v !== 32'hABCD_0000 || tid !== 32'hABCD_0000) begin n_fail++; $display("FAIL tid_hi got=%h/%h exp=abcd0000", v, tid); end
    csr_write(TID, 32'h0000_FFFF, 32'h1111_5678);
    rd(TID, v);
    n_checks++; if (v !== 32'hABCD_5678) begin n_fail++; $display("FAIL tid_lo got=%h exp=abcd5678", v); end
    csr_write(14'h43, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    rd(14'h43, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL read_0x43 got=%h exp=0", v); end
    rd(14'h0, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL read_crmd got=%h exp=0", v); end
  endtask

  task automatic test_reset_midcount;
    csr_write(TCFG, 32'hFFFF_FFFF, 32'h101);
    tick(3);
    resetn = 1'b0;
    tick();
    rd(TVAL, v);
    n_checks++; if (v !== 32'hFFFF_FFFF || timer_int !== 1'b0) begin n_fail++; $display("FAIL midreset_state got=%h int=%b exp=ffffffff int=0", v, timer_int); end
    n_checks++; if (stable_cnt !== 64'd0 || tid !== 32'h0) begin n_fail++; $display("FAIL midreset_cnt_tid got=%0d/%h exp=0/0", stable_cnt, tid); end
    resetn = 1'b1;
    tick(3);
    rd(TVAL, v);
    n_checks++; if (v !== 32'hFFFF_FFFF || stable_cnt !== 64'd3 || timer_int !== 1'b0) begin n_fail++; $display("FAIL midreset_after got=%h cnt=%0d int=%b exp=ffffffff 3 0", v, stable_cnt, timer_int); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_ticlr_race();
    test_freeze_reload();
    test_zero_load();
    test_tid();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
